// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch-stage types and default constants
// Holds the fetch FSM state encoding and the reset / bubble defaults.
// The IF/ID and PC parameters of fetch_stage_ctrl default to these values.
package mips_pkg;

    localparam int          DEF_ADDR_W    = 32;
    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
    // sll $0,$0,0
    localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // no request outstanding
        REQ   = 2'd1,   // request to pc outstanding
        DRAIN = 2'd2,   // stale request outstanding, response will be dropped
        FULL  = 2'd3    // skid holds an instruction, IF/ID stalled
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - one-entry instruction + pc4 holding register
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   load, clr           capture load_data/load_pc4; empty the entry (clr wins)
//   load_data, load_pc4 instruction word and its PC+4 to capture
//   full                entry holds a valid instruction
//   data, pc4           stored instruction and PC+4
module fetch_skid_buf #(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clr,
    input  logic [31:0]       load_data,
    input  logic [ADDR_W-1:0] load_pc4,
    output logic              full,
    output logic [31:0]       data,
    output logic [ADDR_W-1:0] pc4
);

    logic              full_q, full_d;
    logic [31:0]       data_q, data_d;
    logic [ADDR_W-1:0] pc4_q, pc4_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        pc4_d  = pc4_q;
        if (clr) begin
            full_d = 1'b0;
        end else if (load) begin
            full_d = 1'b1;
            data_d = load_data;
            pc4_d  = load_pc4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= NOP_INSTR;
            pc4_q  <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            pc4_q  <= pc4_d;
        end
    end

    assign full = full_q;
    assign data = data_q;
    assign pc4  = pc4_q;

endmodule

// File: rtl/fetch_stage_ctrl.sv
// rtl/fetch_stage_ctrl.sv - PC register, imem request port and IF/ID register
// Optional build macro: FETCH_PERF_CNT_EN adds perf_stall_cyc / perf_flush_cnt.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   pc_stall, if_stall            hazard unit: hold PC / hold IF/ID
//   redirect_valid, redirect_pc   EXE branch/jump: flush and refetch
//   imem_req, imem_addr           registered fetch request (no input->output path)
//   imem_ready, imem_rdata        one-cycle response strobe and instruction
//   if_id_valid/instr/pc4         IF/ID pipeline register
module fetch_stage_ctrl
    import mips_pkg::*;
#(
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(DEF_RESET_PC),
    parameter logic [31:0]       NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_stall,
    input  logic              if_stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic              if_id_valid,
    output logic [31:0]       if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc4
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_stall_cyc,
    output logic [15:0]       perf_flush_cnt
`endif
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              valid_q, valid_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] pc4_q, pc4_d;

    logic              skid_load, skid_clr, skid_full;
    logic [31:0]       skid_data;
    logic [ADDR_W-1:0] skid_pc4;

    // Instructions are word aligned; the low target bits carry no information.
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    fetch_skid_buf #(
        .ADDR_W    (ADDR_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (skid_load),
        .clr       (skid_clr),
        .load_data (imem_rdata),
        .load_pc4  (pc_inc),
        .full      (skid_full),
        .data      (skid_data),
        .pc4       (skid_pc4)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        req_d     = req_q;
        addr_d    = addr_q;
        valid_d   = valid_q;
        instr_d   = instr_q;
        pc4_d     = pc4_q;
        skid_load = 1'b0;
        skid_clr  = 1'b0;
        pc_inc    = pc_q + ADDR_W'(4);

        // When ID consumes IF/ID and nothing new arrives, it becomes a bubble
        // so the same instruction is never issued twice.
        if (!if_stall) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end

        if (redirect_valid) begin
            pc_d     = {redirect_pc[ADDR_W-1:2], 2'b00};
            valid_d  = 1'b0;
            instr_d  = NOP_INSTR;
            skid_clr = 1'b1;
            // A request still in flight must complete on the bus before the
            // new target can be fetched; keep it up and drop its data later.
            if (req_q && !imem_ready) begin
                state_d = DRAIN;
            end else begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (!pc_stall) begin
                        addr_d  = pc_q;
                        req_d   = 1'b1;
                        state_d = REQ;
                    end
                end
                REQ: begin
                    if (imem_ready) begin
                        pc_d = pc_inc;
                        if (!if_stall) begin
                            valid_d = 1'b1;
                            instr_d = imem_rdata;
                            pc4_d   = pc_inc;
                            if (!pc_stall) begin
                                addr_d = pc_inc;   // back-to-back fetch
                            end else begin
                                req_d   = 1'b0;
                                state_d = IDLE;
                            end
                        end else begin
                            skid_load = 1'b1;
                            req_d     = 1'b0;
                            state_d   = FULL;
                        end
                    end
                end
                FULL: begin
                    if (!if_stall) begin
                        valid_d  = 1'b1;
                        instr_d  = skid_data;
                        pc4_d    = skid_pc4;
                        skid_clr = 1'b1;
                        state_d  = IDLE;
                    end
                end
                DRAIN: begin
                    if (imem_ready) begin
                        req_d   = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pc4_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign if_id_valid = valid_q;
    assign if_id_instr = instr_q;
    assign if_id_pc4   = pc4_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cyc_q, stall_cyc_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cyc_d = stall_cyc_q;
        flush_cnt_d = flush_cnt_q;
        if (if_stall && (stall_cyc_q != '1)) begin
            stall_cyc_d = stall_cyc_q + 32'd1;
        end
        if (redirect_valid && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cyc_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cyc_q <= stall_cyc_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_stall_cyc = stall_cyc_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// tb/tb_fetch_stage_ctrl.sv - self-checking bench for fetch_stage_ctrl
module tb_fetch_stage_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst, pc_stall, if_stall, redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        if_id_valid;
    logic [31:0] if_id_instr, if_id_pc4;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_stall_cyc;
    logic [15:0] perf_flush_cnt;
`endif

    always #5 clk = ~clk;

    fetch_stage_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .pc_stall       (pc_stall),
        .if_stall       (if_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc4      (if_id_pc4)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_stall_cyc (perf_stall_cyc),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: what the fetch stage should look like after each edge.
    logic [31:0] m_pc, m_addr, m_instr, m_pc4;
    bit          m_req, m_stale, m_valid;
    logic [63:0] m_skid[$];
    int          m_stall_cyc, m_flush;

    // Memory responder state.
    int max_wait = 0;
    int wait_cnt = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("imem_req",    {31'd0, imem_req},    {31'd0, m_req});
        check("imem_addr",   imem_addr,            m_addr);
        check("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
        check("if_id_instr", if_id_instr,          m_instr);
        check("if_id_pc4",   if_id_pc4,            m_pc4);
    endtask

    // Apply one cycle of inputs (called at a falling edge), advance the model,
    // let the DUT take the rising edge, and compare at the next falling edge.
    task automatic step(input bit r, input bit ps, input bit is, input bit rv,
                        input logic [31:0] rpc);
        bit loaded;
        rst            = r;
        pc_stall       = ps;
        if_stall       = is;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if (m_req) imem_ready = r ? 1'($urandom_range(1, 0)) : (wait_cnt == 0);
        else       imem_ready = 1'b0;
        imem_rdata = imem_ready ? mem_word(m_addr) : $urandom;

        loaded = 1'b0;
        if (r) begin
            m_pc = 32'h0; m_addr = 32'h0; m_req = 0; m_stale = 0;
            m_valid = 0; m_instr = NOP; m_pc4 = 32'h0;
            m_skid.delete();
            m_stall_cyc = 0; m_flush = 0;
        end else begin
            if (is) m_stall_cyc++;
            if (rv) m_flush++;
            if (rv) begin
                m_pc = {rpc[31:2], 2'b00};
                m_skid.delete();
                if (m_req && !imem_ready) m_stale = 1;
                else begin m_req = 0; m_stale = 0; end
            end else if (m_stale) begin
                if (imem_ready) begin m_req = 0; m_stale = 0; end
            end else if (m_skid.size() != 0) begin
                if (!is) begin
                    {m_instr, m_pc4} = m_skid.pop_front();
                    m_valid = 1; loaded = 1;
                end
            end else if (!m_req) begin
                if (!ps) begin m_req = 1; m_addr = m_pc; end
            end else if (imem_ready) begin
                m_pc = m_pc + 32'd4;
                if (!is) begin
                    m_valid = 1; m_instr = imem_rdata; m_pc4 = m_pc; loaded = 1;
                    if (!ps) m_addr = m_pc;
                    else     m_req = 0;
                end else begin
                    m_skid.push_back({imem_rdata, m_pc});
                    m_req = 0;
                end
            end
            if (rv || (!is && !loaded)) begin m_valid = 0; m_instr = NOP; end
        end

        if (r || imem_ready) wait_cnt = $urandom_range(max_wait, 0);
        else if (m_req && wait_cnt > 0) wait_cnt--;

        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        rst = 1'b1; pc_stall = 1'b0; if_stall = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'h0; imem_ready = 1'b0; imem_rdata = 32'h0;
        m_req = 0; m_stale = 0; m_valid = 0; m_pc = 0; m_addr = 0;
        m_instr = NOP; m_pc4 = 0; m_stall_cyc = 0; m_flush = 0;
        @(negedge clk);

        // Reset values.
        step(1, 0, 0, 0, 32'h0);
        step(1, 0, 0, 0, 32'h0);
        check("rst_req",   {31'd0, imem_req},    32'd0);
        check("rst_addr",  imem_addr,            32'h0);
        check("rst_valid", {31'd0, if_id_valid}, 32'd0);
        check("rst_instr", if_id_instr,          NOP);
        check("rst_pc4",   if_id_pc4,            32'h0);

        // First request one cycle after reset, then one instruction per cycle.
        step(0, 0, 0, 0, 32'h0);
        check("first_req",  {31'd0, imem_req}, 32'd1);
        check("first_addr", imem_addr,         32'h0);
        step(0, 0, 0, 0, 32'h0);
        check("pc4_seq0", if_id_pc4, 32'h4);
        step(0, 0, 0, 0, 32'h0);
        check("pc4_seq1", if_id_pc4, 32'h8);
        step(0, 0, 0, 0, 32'h0);
        check("pc4_seq2", if_id_pc4, 32'hC);

        // Two-cycle hazard stall: the in-flight response lands in the skid.
        step(0, 1, 1, 0, 32'h0);
        step(0, 1, 1, 0, 32'h0);
        check("stall_hold_pc4", if_id_pc4, 32'hC);
        step(0, 0, 0, 0, 32'h0);
        check("skid_release_pc4",   if_id_pc4,   32'h10);
        check("skid_release_instr", if_id_instr, mem_word(32'hC));

        // Redirect to 0x40 while a three-wait request for 0x10 is outstanding.
        step(0, 0, 0, 0, 32'h0);
        check("req_0x10", imem_addr, 32'h10);
        wait_cnt = 3;
        step(0, 0, 0, 1, 32'h40);
        check("drain_valid", {31'd0, if_id_valid}, 32'd0);
        check("drain_addr",  imem_addr,            32'h10);
        step(0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        check("refetch_addr", imem_addr,         32'h40);
        check("refetch_req",  {31'd0, imem_req}, 32'd1);

        // Redirect together with if_stall and imem_ready: the flush wins.
        step(0, 0, 1, 1, 32'h80);
        step(0, 0, 0, 0, 32'h0);
        check("flush_wins_addr", imem_addr, 32'h80);

        // Reset while a request is outstanding.
        step(1, 0, 0, 0, 32'h0);
        check("midrst_req",  {31'd0, imem_req}, 32'd0);
        check("midrst_addr", imem_addr,         32'h0);

        // PC wrap past the top of the address space; low target bits ignored.
        step(0, 0, 0, 1, 32'hFFFF_FFFF);
        step(0, 0, 0, 0, 32'h0);
        check("wrap_req_addr", imem_addr, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 32'h0);
        check("wrap_pc4",  if_id_pc4, 32'h0);
        check("wrap_next", imem_addr, 32'h0);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) max_wait = $urandom_range(3, 0);
            step(($urandom_range(99, 0) == 0),
                 ($urandom_range(3, 0) == 0),
                 ($urandom_range(3, 0) == 0),
                 ($urandom_range(11, 0) == 0),
                 $urandom);
        end

`ifdef FETCH_PERF_CNT_EN
        check("perf_stall_cyc", perf_stall_cyc,          32'(m_stall_cyc));
        check("perf_flush_cnt", {16'd0, perf_flush_cnt}, 32'(m_flush));
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
